// File: rtl/lb_pkg.sv
// Shared encodings for the keyboard decoder: directions, PS/2 set-2 codes, prefix states.
// No logic of its own; key indices give each mapped key a fixed bit in the held-flag vector.
// Helpers are pure combinational functions used by the decoder and the direction registers.
package lb_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } pfx_state_e;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_W        = 8'h1D;
    localparam logic [7:0] SC_S        = 8'h1B;
    localparam logic [7:0] SC_A        = 8'h1C;
    localparam logic [7:0] SC_D        = 8'h23;
    localparam logic [7:0] SC_SPACE    = 8'h29;
    localparam logic [7:0] SC_ESC      = 8'h76;
    localparam logic [7:0] SC_ARR_UP   = 8'h75;
    localparam logic [7:0] SC_ARR_DOWN = 8'h72;
    localparam logic [7:0] SC_ARR_LEFT = 8'h6B;
    localparam logic [7:0] SC_ARR_RGHT = 8'h74;

    localparam int NUM_KEYS     = 10;
    localparam int KEY_W        = 0;
    localparam int KEY_S        = 1;
    localparam int KEY_A        = 2;
    localparam int KEY_D        = 3;
    localparam int KEY_SPACE    = 4;
    localparam int KEY_ESC      = 5;
    localparam int KEY_P2_UP    = 6;
    localparam int KEY_P2_DOWN  = 7;
    localparam int KEY_P2_LEFT  = 8;
    localparam int KEY_P2_RIGHT = 9;

    // One-hot key for a non-prefix byte; the extended flag selects the arrow-key page.
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] oh;
        oh = '0;
        if (!ext) begin
            case (code)
                SC_W:     oh[KEY_W]     = 1'b1;
                SC_S:     oh[KEY_S]     = 1'b1;
                SC_A:     oh[KEY_A]     = 1'b1;
                SC_D:     oh[KEY_D]     = 1'b1;
                SC_SPACE: oh[KEY_SPACE] = 1'b1;
                SC_ESC:   oh[KEY_ESC]   = 1'b1;
                default:  oh = '0;
            endcase
        end else begin
            case (code)
                SC_ARR_UP:   oh[KEY_P2_UP]    = 1'b1;
                SC_ARR_DOWN: oh[KEY_P2_DOWN]  = 1'b1;
                SC_ARR_LEFT: oh[KEY_P2_LEFT]  = 1'b1;
                SC_ARR_RGHT: oh[KEY_P2_RIGHT] = 1'b1;
                default:     oh = '0;
            endcase
        end
        return oh;
    endfunction

    // Direction from a one-hot {RIGHT, LEFT, DOWN, UP} group of key bits.
    function automatic logic [1:0] dir_of_onehot(input logic [3:0] oh);
        return {oh[2] | oh[3], oh[1] | oh[3]};
    endfunction

    // UP/DOWN and LEFT/RIGHT share the upper bit and differ in the lower one.
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/lb_dir_reg.sv
// Per-player direction register: holds one pending request, commits it on tick unless it reverses.
// Latency: committed direction changes one clock after the tick edge.
// No backpressure: a newer request simply overwrites the pending one.
module lb_dir_reg
    import lb_pkg::*;
#(
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       round_init,
    input  logic       req_vld,
    input  logic [1:0] req_dir,
    output logic [1:0] dir
);

    logic [1:0] pend_dir_q;
    logic       pend_vld_q;
    logic [1:0] dir_d;
    logic [1:0] pend_dir_d;
    logic       pend_vld_d;

    // A request in the same cycle as tick/round_init lands after them and waits for the next tick.
    always_comb begin
        dir_d      = dir;
        pend_dir_d = pend_dir_q;
        pend_vld_d = pend_vld_q;
        if (round_init) begin
            dir_d      = INIT_DIR;
            pend_vld_d = 1'b0;
        end else if (tick) begin
            if (pend_vld_q && !is_opposite(pend_dir_q, dir)) begin
                dir_d = pend_dir_q;
            end
            pend_vld_d = 1'b0;
        end
        if (req_vld) begin
            pend_dir_d = req_dir;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir        <= INIT_DIR;
            pend_dir_q <= INIT_DIR;
            pend_vld_q <= 1'b0;
        end else begin
            dir        <= dir_d;
            pend_dir_q <= pend_dir_d;
            pend_vld_q <= pend_vld_d;
        end
    end

endmodule

// File: rtl/lb_key_decoder.sv
// PS/2 set-2 keyboard decoder for a two-player game: prefix FSM, autorepeat filter, direction requests.
// Latency: pulses and last_code one clock after scan_ready; directions one clock after tick.
// No backpressure: every scan_ready byte is consumed in its own cycle.
module lb_key_decoder
    import lb_pkg::*;
#(
    parameter logic [1:0] P1_INIT_DIR = 2'd3,
    parameter logic [1:0] P2_INIT_DIR = 2'd2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scan_ready,
    input  logic [7:0] scan_code,
    input  logic       tick,
    input  logic       round_init,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       start_pulse,
    output logic       abort_pulse,
    output logic [7:0] last_code
);

    pfx_state_e          state_q;
    pfx_state_e          state_d;
    logic [NUM_KEYS-1:0] held_q;
    logic [NUM_KEYS-1:0] held_d;
    logic [NUM_KEYS-1:0] make_new;
    logic [NUM_KEYS-1:0] key_oh;
    logic                dec_vld;
    logic                dec_ext;
    logic                dec_brk;
    logic                p1_req_vld;
    logic [1:0]          p1_req_dir;
    logic                p2_req_vld;
    logic [1:0]          p2_req_dir;

    always_comb begin
        state_d = state_q;
        dec_vld = 1'b0;
        dec_ext = 1'b0;
        dec_brk = 1'b0;
        if (scan_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        dec_vld = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scan_code == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (scan_code == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        dec_vld = 1'b1;
                        dec_ext = 1'b1;
                    end
                end
                ST_BRK: begin
                    dec_vld = 1'b1;
                    dec_brk = 1'b1;
                end
                ST_EXT_BRK: begin
                    dec_vld = 1'b1;
                    dec_ext = 1'b1;
                    dec_brk = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (dec_vld) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Held flags filter typematic repeats: only the first make after a break acts.
    always_comb begin
        held_d   = held_q;
        make_new = '0;
        key_oh   = key_onehot(dec_ext, scan_code);
        if (dec_vld) begin
            if (dec_brk) begin
                held_d = held_q & ~key_oh;
            end else begin
                make_new = key_oh & ~held_q;
                held_d   = held_q | key_oh;
            end
        end
    end

    assign p1_req_vld = |make_new[KEY_D:KEY_W];
    assign p1_req_dir = dir_of_onehot(make_new[KEY_D:KEY_W]);
    assign p2_req_vld = |make_new[KEY_P2_RIGHT:KEY_P2_UP];
    assign p2_req_dir = dir_of_onehot(make_new[KEY_P2_RIGHT:KEY_P2_UP]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            held_q      <= '0;
            start_pulse <= 1'b0;
            abort_pulse <= 1'b0;
            last_code   <= 8'h00;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            start_pulse <= make_new[KEY_SPACE];
            abort_pulse <= make_new[KEY_ESC];
            if (scan_ready && scan_code != SC_EXT && scan_code != SC_BRK) begin
                last_code <= scan_code;
            end
        end
    end

    lb_dir_reg #(
        .INIT_DIR (P1_INIT_DIR)
    ) u_p1_dir (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .round_init (round_init),
        .req_vld    (p1_req_vld),
        .req_dir    (p1_req_dir),
        .dir        (p1_dir)
    );

    lb_dir_reg #(
        .INIT_DIR (P2_INIT_DIR)
    ) u_p2_dir (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .round_init (round_init),
        .req_vld    (p2_req_vld),
        .req_dir    (p2_req_dir),
        .dir        (p2_dir)
    );

endmodule

// File: doc/lb_key_decoder.md
LB_KEY_DECODER -- requirements
Module: lb_key_decoder

Interface
REQ-001 Parameter P1_INIT_DIR, default 2'd3 (RIGHT): player-1 direction loaded on reset and on round_init.
REQ-002 Parameter P2_INIT_DIR, default 2'd2 (LEFT): player-2 direction loaded on reset and on round_init.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 scan_ready  in  1  one-cycle strobe; scan_code is valid in that cycle.
REQ-006 scan_code  in  8  PS/2 set-2 byte from the keyboard receiver.
REQ-007 tick  in  1  one-cycle game-step strobe; pending direction requests commit here.
REQ-008 round_init  in  1  one-cycle strobe; reloads directions and clears pending requests.
REQ-009 p1_dir  out  2  committed player-1 direction: UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-010 p2_dir  out  2  committed player-2 direction, same encoding as p1_dir.
REQ-011 start_pulse  out  1  one-cycle pulse on a Space (0x29) make, first press only.
REQ-012 abort_pulse  out  1  one-cycle pulse on an Esc (0x76) make, first press only.
REQ-013 last_code  out  8  last non-prefix byte received, for seven-segment debug display.

Function
REQ-014 The prefix FSM SHALL have four states, IDLE, EXT, BRK and EXT_BRK, and SHALL advance only in cycles where scan_ready=1.
REQ-015 Prefix transitions SHALL be: IDLE on 0xE0 -> EXT; IDLE on 0xF0 -> BRK; EXT on 0xF0 -> EXT_BRK; EXT on 0xE0 -> EXT.
REQ-016 Any other byte SHALL be decoded according to the current state, and the FSM SHALL return to IDLE.
REQ-017 Make codes decoded from IDLE SHALL be: W=0x1D UP, S=0x1B DOWN, A=0x1C LEFT, D=0x23 RIGHT (player 1); Space=0x29; Esc=0x76.
REQ-018 Make codes decoded from EXT SHALL be: 0x75 UP, 0x72 DOWN, 0x6B LEFT, 0x74 RIGHT (player 2).
REQ-019 Decoding from BRK or EXT_BRK SHALL clear the held flag of the matching key and SHALL produce no other effect.
REQ-020 Each of the 10 mapped keys SHALL have a held flag; a make code arriving while that flag is set is autorepeat and SHALL be ignored.
REQ-021 Unmapped codes SHALL be ignored apart from updating last_code.
REQ-022 A direction make SHALL overwrite the player's pending request and set its pending-valid bit; the latest press before a tick wins.
REQ-023 On tick with pending-valid set, the pending direction SHALL commit unless it is the opposite of the committed direction (UP/DOWN, LEFT/RIGHT).
REQ-024 On tick, pending-valid SHALL clear whether the request commits or is rejected; a request equal to the current direction commits with no change.
REQ-025 A scan_ready in the same cycle as tick SHALL be decoded after the commit and become pending for the next tick.
REQ-026 round_init SHALL load P1_INIT_DIR and P2_INIT_DIR and clear both pending-valid bits, taking priority over a tick in the same cycle.
REQ-027 round_init SHALL NOT alter the FSM state or the held flags.
REQ-028 start_pulse and abort_pulse SHALL be registered, asserted in the cycle after the qualifying scan_ready and high for exactly one cycle.
REQ-029 Committed-direction latency SHALL be one clock after the tick edge.

Reset
REQ-030 With reset_n=0 the block SHALL asynchronously force FSM=IDLE, all held flags and pending-valid bits to 0, p1_dir=P1_INIT_DIR, p2_dir=P2_INIT_DIR, start_pulse=0, abort_pulse=0 and last_code=0x00.
REQ-031 A reset asserted mid-prefix, for example after 0xE0, SHALL discard the partial sequence.

Structure
REQ-032 Package lb_pkg SHALL hold the direction encoding, all scan-code constants and the prefix-FSM state enum.
REQ-033 The per-player pending/commit/reversal logic SHALL be a sub-module, lb_dir_reg, instantiated twice.

Verification
REQ-034 Reset, then scan 0x1D, then tick -> p1_dir goes 3 -> 0.
REQ-035 p1_dir=RIGHT; scan 0x1C, then tick -> p1_dir stays 3 and pending is cleared.
REQ-036 Scan E0,75 then E0,6B, then tick -> p2_dir=2, the last request winning.
REQ-037 Scan 0x29 three times without F0 -> exactly one start_pulse; then F0,29 followed by 29 -> a second start_pulse.
REQ-038 Pending p1 DOWN with tick and round_init in the same cycle -> p1_dir=3 and pending cleared.
REQ-039 Scan E0, assert reset_n low, release, then scan 0x75 -> no player-2 change and last_code=0x75.
